// File: rtl/multdiv_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller:
// operation encodings, controller state enum and small decode helpers.
package multdiv_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5,
    OP_MFHI  = 3'd6,
    OP_MFLO  = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    BUSY  = 2'd2,
    DRAIN = 2'd3
  } state_e;

  // MULT/MULTU select the multiplier; DIV/DIVU select the divider.
  function automatic logic op_is_mult(input op_e op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  // MULT and DIV are the two's-complement variants.
  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/multdiv_ctrl.sv
// Pipeline-side controller for an external multiply/divide unit.
// Owns the HI/LO registers, sequences one mult/div at a time, serves
// MTHI/MTLO/MFHI/MFLO, and tracks a sticky divide-by-zero flag.
//
// Handshake: an op is transferred on a rising clk edge where
// op_valid && op_ready. op_ready depends only on the FSM state (high
// only in IDLE) and never on op_valid, so the pipeline may hold
// op_valid and wait. mf_valid is a one-cycle pulse carrying mf_data.
module multdiv_ctrl
  import multdiv_pkg::*;
(
  input  logic              clk,
  input  logic              resetb,
  input  logic              op_valid,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              flush,
  output logic              op_ready,
  output logic [DATA_W-1:0] mf_data,
  output logic              mf_valid,
  output logic              dbz,
  output logic              md_start,
  output logic              md_multdivb,
  output logic              md_signedop,
  output logic [DATA_W-1:0] md_x,
  output logic [DATA_W-1:0] md_y,
  input  logic [DATA_W-1:0] md_prodh,
  input  logic [DATA_W-1:0] md_prodl,
  input  logic              md_run,
  input  logic              md_dividebyzero,
  output state_e            o_state_dbg
);

  state_e            r_state;
  state_e            w_state_nxt;
  logic              r_first;      // first cycle of BUSY/DRAIN: md_run not yet valid
  logic              w_first_nxt;
  logic              r_discard;
  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] r_mf_data;
  logic              r_mf_valid;
  logic              r_dbz;
  logic [DATA_W-1:0] r_md_x;
  logic [DATA_W-1:0] r_md_y;
  logic              r_md_multdivb;
  logic              r_md_signedop;

  op_e               w_op;
  logic              w_op_ready;
  logic              w_md_start;
  logic              w_load_md;
  logic              w_mt_hi;
  logic              w_mt_lo;
  logic              w_mf;
  logic              w_complete;
  logic              w_set_discard;
  logic              w_clr_discard;

  assign w_op = op_e'(op);

  // State register and first-cycle marker.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_state <= IDLE;
      r_first <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_first <= w_first_nxt;
    end
  end

  // Next-state logic and per-cycle control strobes.
  always_comb begin
    w_state_nxt   = r_state;
    w_first_nxt   = 1'b0;
    w_op_ready    = 1'b0;
    w_md_start    = 1'b0;
    w_load_md     = 1'b0;
    w_mt_hi       = 1'b0;
    w_mt_lo       = 1'b0;
    w_mf          = 1'b0;
    w_complete    = 1'b0;
    w_set_discard = 1'b0;
    w_clr_discard = 1'b0;
    case (r_state)
      IDLE: begin
        w_op_ready = 1'b1;
        // A flush arriving with an op cancels that op outright.
        if (op_valid && !flush) begin
          case (w_op)
            OP_MTHI:          w_mt_hi = 1'b1;
            OP_MTLO:          w_mt_lo = 1'b1;
            OP_MFHI, OP_MFLO: w_mf    = 1'b1;
            default: begin
              w_load_md   = 1'b1;
              w_state_nxt = START;
            end
          endcase
        end
      end
      START: begin
        w_md_start  = 1'b1;
        w_first_nxt = 1'b1;
        if (flush) begin
          w_set_discard = 1'b1;
          w_state_nxt   = DRAIN;
        end else begin
          w_state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (flush) begin
          w_set_discard = 1'b1;
          w_first_nxt   = 1'b1;
          w_state_nxt   = DRAIN;
        end else if (!r_first && !md_run) begin
          w_complete  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      DRAIN: begin
        // The unit is still running; wait it out without keeping the result.
        if (!r_first && !md_run) begin
          w_clr_discard = 1'b1;
          w_state_nxt   = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // HI/LO, read-back, operand latches, sticky dbz and discard flag.
  always_ff @(posedge clk) begin
    if (!resetb) begin
      r_hi          <= '0;
      r_lo          <= '0;
      r_mf_data     <= '0;
      r_mf_valid    <= 1'b0;
      r_dbz         <= 1'b0;
      r_md_x        <= '0;
      r_md_y        <= '0;
      r_md_multdivb <= 1'b0;
      r_md_signedop <= 1'b0;
      r_discard     <= 1'b0;
    end else begin
      r_mf_valid <= w_mf;
      if (w_mf) begin
        r_mf_data <= (w_op == OP_MFHI) ? r_hi : r_lo;
      end
      if (w_mt_hi) begin
        r_hi <= rs_data;
      end
      if (w_mt_lo) begin
        r_lo <= rs_data;
      end
      if (w_load_md) begin
        r_md_x        <= rs_data;
        r_md_y        <= rt_data;
        r_md_multdivb <= op_is_mult(w_op);
        r_md_signedop <= op_is_signed(w_op);
        r_dbz         <= 1'b0;
      end
      if (w_complete && !r_discard) begin
        if (!r_md_multdivb && md_dividebyzero) begin
          r_dbz <= 1'b1;
        end else begin
          r_hi <= md_prodh;
          r_lo <= md_prodl;
        end
      end
      if (w_set_discard) begin
        r_discard <= 1'b1;
      end else if (w_clr_discard) begin
        r_discard <= 1'b0;
      end
    end
  end

  assign op_ready    = w_op_ready;
  assign md_start    = w_md_start;
  assign mf_data     = r_mf_data;
  assign mf_valid    = r_mf_valid;
  assign dbz         = r_dbz;
  assign md_x        = r_md_x;
  assign md_y        = r_md_y;
  assign md_multdivb = r_md_multdivb;
  assign md_signedop = r_md_signedop;
  assign o_state_dbg = r_state;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl with a behavioural multiply/divide unit.
module tb_multdiv_ctrl;
  import multdiv_pkg::*;

  localparam int UNIT_LAT = 4;
  localparam int WAIT_MAX = 200;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        resetb;
  always #5 clk = ~clk;

  logic        op_valid;
  logic [2:0]  op;
  logic [31:0] rs_data, rt_data;
  logic        flush;
  logic        op_ready;
  logic [31:0] mf_data;
  logic        mf_valid;
  logic        dbz;
  logic        md_start, md_multdivb, md_signedop;
  logic [31:0] md_x, md_y, md_prodh, md_prodl;
  logic        md_run, md_dividebyzero;
  state_e      state_dbg;

  multdiv_ctrl dut (
    .clk(clk), .resetb(resetb), .op_valid(op_valid), .op(op),
    .rs_data(rs_data), .rt_data(rt_data), .flush(flush),
    .op_ready(op_ready), .mf_data(mf_data), .mf_valid(mf_valid), .dbz(dbz),
    .md_start(md_start), .md_multdivb(md_multdivb), .md_signedop(md_signedop),
    .md_x(md_x), .md_y(md_y), .md_prodh(md_prodh), .md_prodl(md_prodl),
    .md_run(md_run), .md_dividebyzero(md_dividebyzero), .o_state_dbg(state_dbg)
  );

  // ---------------- behavioural mult/div unit ----------------
  function automatic logic [64:0] unit_calc(input logic mul, input logic sgn,
                                            input logic [31:0] x, input logic [31:0] y);
    logic [63:0] a, b;
    int sx, sy;
    if (mul) begin
      a = sgn ? {{32{x[31]}}, x} : {32'b0, x};
      b = sgn ? {{32{y[31]}}, y} : {32'b0, y};
      return {1'b0, a * b};
    end
    if (y == 32'd0) return {1'b1, 64'hDEAD_BEEF_DEAD_BEEF};
    if (sgn) begin
      sx = x;
      sy = y;
      return {1'b0, 32'(sx % sy), 32'(sx / sy)};
    end
    return {1'b0, x % y, x / y};
  endfunction

  int unsigned unit_cnt;
  always @(posedge clk) begin
    if (!resetb) begin
      md_run <= 1'b0; unit_cnt <= 0;
      md_prodh <= '0; md_prodl <= '0; md_dividebyzero <= 1'b0;
    end else if (md_start) begin
      md_run   <= 1'b1;
      unit_cnt <= UNIT_LAT;
      {md_dividebyzero, md_prodh, md_prodl} <= unit_calc(md_multdivb, md_signedop, md_x, md_y);
    end else if (unit_cnt != 0) begin
      unit_cnt <= unit_cnt - 1;
      if (unit_cnt == 1) md_run <= 1'b0;
    end
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Scoreboard for MFHI/MFLO results.
  logic [31:0] exp_q[$];
  always @(negedge clk) begin
    if (resetb && mf_valid) begin
      if (exp_q.size() == 0) chk("mf_spurious_valid", 32'(mf_valid), 32'd0);
      else chk("mf_data", mf_data, exp_q.pop_front());
    end
  end

  // Monitors: start pulse count, and op_ready must never be high while the unit runs.
  int start_cnt = 0;
  int ready_bad = 0;
  always @(negedge clk) begin
    if (resetb && md_start) start_cnt++;
    if (resetb && md_run && op_ready) ready_bad++;
  end

  // ---------------- driver tasks ----------------
  // Called #1 after a rising edge; returns #1 after the accepting edge.
  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic fl, output int waits);
    waits = 0;
    op_valid = 1'b1; op = o; rs_data = a; rt_data = b; flush = fl;
    while (!op_ready && waits < WAIT_MAX) begin
      @(posedge clk); #1;
      waits++;
    end
    if (!op_ready) chk("accept_timeout", 32'(op_ready), 32'd1);
    @(posedge clk); #1;
    op_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic mf_read(input logic [2:0] o, input logic [31:0] expv);
    int w;
    exp_q.push_back(expv);
    issue(o, 32'h0, 32'h0, 1'b0, w);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!op_ready && n < WAIT_MAX) begin
      @(posedge clk); #1;
      n++;
    end
    chk(tag, 32'(op_ready), 32'd1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int w;
    resetb = 1'b0; op_valid = 1'b0; op = '0; rs_data = '0; rt_data = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1 resetb = 1'b1;
    @(negedge clk);
    chk("rst_ready", 32'(op_ready), 32'd1);
    chk("rst_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_mf_valid", 32'(mf_valid), 32'd0);
    chk("rst_mf_data", mf_data, 32'd0);
    chk("rst_dbz", 32'(dbz), 32'd0);
    chk("rst_md_start", 32'(md_start), 32'd0);
    chk("rst_md_x", md_x, 32'd0);
    chk("rst_md_y", md_y, 32'd0);
    chk("rst_md_flags", {30'd0, md_multdivb, md_signedop}, 32'd0);
    @(posedge clk); #1;

    // MULTU all-ones
    start_cnt = 0;
    issue(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, w);
    chk("multu_start", 32'(md_start), 32'd1);
    chk("multu_flags", {30'd0, md_multdivb, md_signedop}, 32'b10);
    chk("multu_x", md_x, 32'hFFFF_FFFF);
    @(posedge clk); #1;
    chk("multu_start_gone", 32'(md_start), 32'd0);
    chk("multu_busy_ready", 32'(op_ready), 32'd0);
    chk("multu_x_held", md_x, 32'hFFFF_FFFF);
    wait_idle("multu_done");
    chk("multu_start_pulses", 32'(start_cnt), 32'd1);
    mf_read(OP_MFHI, 32'hFFFF_FFFE);
    mf_read(OP_MFLO, 32'h0000_0001);

    // MULT then immediate MFHI (must stall)
    issue(OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002, 1'b0, w);
    exp_q.push_back(32'hFFFF_FFFF);
    issue(OP_MFHI, 32'h0, 32'h0, 1'b0, w);
    chk("mfhi_stalled", 32'(w > 0), 32'd1);
    mf_read(OP_MFLO, 32'hFFFF_FFFE);

    // DIVU / DIV
    issue(OP_DIVU, 32'd7, 32'd2, 1'b0, w);
    chk("divu_flags", {30'd0, md_multdivb, md_signedop}, 32'b00);
    wait_idle("divu_done");
    mf_read(OP_MFLO, 32'h0000_0003);
    mf_read(OP_MFHI, 32'h0000_0001);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, w);
    chk("div_flags", {30'd0, md_multdivb, md_signedop}, 32'b01);
    wait_idle("div_done");
    mf_read(OP_MFLO, 32'hFFFF_FFFD);
    mf_read(OP_MFHI, 32'hFFFF_FFFF);

    // MTHI then divide by zero
    issue(OP_MTHI, 32'h1234_5678, 32'h0, 1'b0, w);
    chk("mthi_stays_idle", 32'(state_dbg), 32'(IDLE));
    issue(OP_DIV, 32'd5, 32'd0, 1'b0, w);
    wait_idle("dbz_done");
    chk("dbz_set", 32'(dbz), 32'd1);
    mf_read(OP_MFHI, 32'h1234_5678);
    mf_read(OP_MFLO, 32'hFFFF_FFFD);
    chk("dbz_sticky", 32'(dbz), 32'd1);
    issue(OP_MULT, 32'd1, 32'd1, 1'b0, w);
    chk("dbz_cleared", 32'(dbz), 32'd0);
    wait_idle("mult11_done");

    // MTLO, MULT 3*5, flush in second BUSY cycle
    issue(OP_MTLO, 32'hA5A5_A5A5, 32'h0, 1'b0, w);
    issue(OP_MULT, 32'd3, 32'd5, 1'b0, w);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("flush_in_busy", 32'(state_dbg), 32'(BUSY));
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_drain", 32'(state_dbg), 32'(DRAIN));
    chk("drain_ready", 32'(op_ready), 32'd0);
    wait_idle("drain_done");
    mf_read(OP_MFLO, 32'hA5A5_A5A5);
    mf_read(OP_MFHI, 32'h0000_0000);

    // flush alone in IDLE, and flush with an accepted MTHI
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("idle_flush", 32'(state_dbg), 32'(IDLE));
    issue(OP_MTHI, 32'hCAFE_F00D, 32'h0, 1'b1, w);
    mf_read(OP_MFHI, 32'h0000_0000);

    // reset in the middle of BUSY
    issue(OP_MULT, 32'd7, 32'd9, 1'b0, w);
    @(posedge clk); #1;
    resetb = 1'b0;
    @(posedge clk); #1;
    resetb = 1'b1;
    chk("rst_busy_state", 32'(state_dbg), 32'(IDLE));
    chk("rst_busy_ready", 32'(op_ready), 32'd1);
    chk("rst_busy_start", 32'(md_start), 32'd0);
    chk("rst_busy_md_x", md_x, 32'd0);
    mf_read(OP_MFHI, 32'h0000_0000);
    mf_read(OP_MFLO, 32'h0000_0000);
    issue(OP_MULTU, 32'd2, 32'd3, 1'b0, w);
    wait_idle("multu23_done");
    mf_read(OP_MFLO, 32'h0000_0006);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    chk("ready_while_run", 32'(ready_bad), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port resetb, input, 1 bit: reset, synchronous and active-low.
REQ-003 SHALL have port op_valid, input, 1 bit: pipeline presents an operation this cycle.
REQ-004 SHALL have port op, input, 3 bits: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
REQ-005 SHALL have ports rs_data and rt_data, inputs, 32 bits each: operands (x=rs, y=rt; MTHI/MTLO use rs).
REQ-006 SHALL have port flush, input, 1 bit: cancel the in-flight mult/div result.
REQ-007 SHALL have port op_ready, output, 1 bit: op is accepted when op_valid and op_ready.
REQ-008 SHALL have ports mf_data, output, 32 bits, and mf_valid, output, 1 bit: MFHI/MFLO result.
REQ-009 SHALL have port dbz, output, 1 bit: sticky divide-by-zero status.
REQ-010 SHALL have multdiv-side ports md_start, md_multdivb, md_signedop (outputs, 1 bit); md_x, md_y (outputs, 32 bits); md_prodh, md_prodl (inputs, 32 bits); md_run, md_dividebyzero (inputs, 1 bit).

Function
REQ-011 SHALL implement FSM states IDLE, START, BUSY, DRAIN.
REQ-012 SHALL drive op_ready = 1 only in IDLE.
REQ-013 Accepted MULT/MULTU/DIV/DIVU SHALL latch rs/rt into md_x/md_y, set md_multdivb (1 mult, 0 div) and md_signedop (1 for MULT/DIV), clear dbz, and go to START.
REQ-014 START SHALL assert md_start for exactly one cycle, then go to BUSY; md_start SHALL be 0 in every other state.
REQ-015 md_x, md_y, md_multdivb and md_signedop SHALL hold stable from START until the FSM returns to IDLE.
REQ-016 BUSY SHALL ignore md_run in its first cycle (the unit raises run the cycle after start); thereafter md_run=0 completes the operation.
REQ-017 On completion without pending flush: if md_dividebyzero=1 on a divide, HI/LO SHALL be left unchanged and dbz set to 1; otherwise HI<=md_prodh and LO<=md_prodl. The FSM then returns to IDLE.
REQ-018 flush in START or BUSY SHALL set a discard flag and move to DRAIN; DRAIN SHALL wait for md_run=0 with the same first-cycle rule, write neither HI/LO nor dbz, and return to IDLE.
REQ-019 flush in IDLE SHALL have no effect; flush together with an accepted op SHALL drop that op.
REQ-020 Accepted MTHI/MTLO SHALL write rs_data to HI/LO on the accepting edge, and the FSM SHALL remain in IDLE.
REQ-021 Accepted MFHI/MFLO SHALL register HI/LO into mf_data with mf_valid=1 in the next cycle only (latency 1).
REQ-022 MFHI/MFLO, MTHI/MTLO and new mult/div SHALL be stalled (op_ready=0) while the FSM is not in IDLE, so a read after a mult/div always returns the new result.
REQ-023 In the completion cycle op_ready SHALL remain 0; the next op is accepted no earlier than the following cycle.
REQ-024 dbz SHALL hold until the next accepted mult/div or reset.

Reset
REQ-025 resetb=0 at a clock edge SHALL force IDLE, HI=LO=0, mf_data=0, mf_valid=0, dbz=0, md_start=0, md_x=md_y=0, md_multdivb=0, md_signedop=0, and discard=0.
REQ-026 Reset during START/BUSY/DRAIN SHALL abandon the operation; the multdiv unit is reset by the same resetb, so no drain is needed.

Structure
REQ-027 The op encodings and FSM state enum SHALL live in shared package multdiv_pkg.
REQ-028 HI/LO SHALL be held inside multdiv_ctrl; the multdiv datapath SHALL be instantiated by the parent, not inside this block, and no sub-module is needed.

Verification
REQ-029 MULTU 0xFFFFFFFF,0xFFFFFFFF -> md_start pulses once, op_ready low until run falls, then MFHI=FFFFFFFE and MFLO=00000001.
REQ-030 MULT 0xFFFFFFFF,0x00000002 followed by MFHI in the next cycle -> MFHI stalls until completion, returns FFFFFFFF; then MFLO returns FFFFFFFE.
REQ-031 DIVU 7,2 -> LO=00000003, HI=00000001; DIV 0xFFFFFFF9,2 -> LO=FFFFFFFD, HI=FFFFFFFF.
REQ-032 MTHI 0x12345678, then DIV x,0 -> dbz=1, MFHI returns 12345678; the next MULT clears dbz.
REQ-033 MTLO 0xA5A5A5A5, MULT 3,5, flush in the second BUSY cycle -> op_ready stays 0 until run falls, then MFLO returns A5A5A5A5.
REQ-034 resetb low mid-BUSY -> next cycle IDLE, op_ready=1, HI=LO=0, md_start=0; a following MULTU 2,3 gives LO=00000006.
